// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// State encoding, default geometry and the saturation helpers.
package bin_to_bcd_seq_pkg;

    localparam int DEF_BIN_W  = 17;
    localparam int DEF_DIGITS = 5;
    localparam int DEF_CNT_W  = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;

    localparam logic [4*DEF_DIGITS-1:0] BCD_MAX = {DEF_DIGITS{4'h9}};

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// One double-dabble digit correction: add 3 when the nibble is 5 or more.
// Purely combinational; the top instantiates one per BCD digit.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Saturates to all nines with ovf set when the value exceeds the digits.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int SW = 4 * DIGITS;
    localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};
    localparam longint unsigned LIMIT = pow10(DIGITS) - 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] binreg;
    logic [SW-1:0]    scr;
    logic [SW-1:0]    adj;
    logic [SW-1:0]    scr_nxt;
    logic             ovf_pend;
    logic             accept;
    logic             last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scr[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    assign accept  = start && (state == S_IDLE || state == S_FIN);
    assign last    = (state == S_SHIFT) && (cnt == CNT_W'(1));
    assign scr_nxt = {adj[SW-2:0], binreg[BIN_W-1]};
    assign busy    = (state == S_SHIFT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            binreg   <= '0;
            scr      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state    <= S_SHIFT;
                binreg   <= bin;
                scr      <= '0;
                cnt      <= CNT_W'(BIN_W);
                ovf_pend <= (64'(bin) > LIMIT);
            end else begin
                unique case (state)
                    S_SHIFT: begin
                        scr    <= scr_nxt;
                        binreg <= {binreg[BIN_W-2:0], 1'b0};
                        cnt    <= cnt - CNT_W'(1);
                        // The edge that consumes the last bit commits the result.
                        if (last) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            bcd   <= ovf_pend ? NINES : scr_nxt;
                            ovf   <= ovf_pend;
                        end
                    end
                    S_FIN:   state <= S_IDLE;
                    S_IDLE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq.
// Expected digits come from decimal arithmetic on the captured value.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [16:0] bin = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        r = '0;
        if (v > 99999) return 20'h99999;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Called just after the accepting edge; counts that edge as edge 1.
    task automatic wait_done(output int edges, output int busyc,
                             output bit ok);
        edges = 1;
        busyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            busyc += int'(busy);
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic convert(input int unsigned v, input string tag);
        int e;
        int b;
        bit ok;
        @(negedge clk);
        bin = 17'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin = 17'($urandom);
        wait_done(e, b, ok);
        chk({tag, "_done"}, 32'(ok), 1);
        if (ok) begin
            chk({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(v)));
            chk({tag, "_ovf"}, 32'(ovf), 32'(v > 99999));
            chk({tag, "_busy_fin"}, 32'(busy), 0);
            chk({tag, "_edges"}, 32'(e), 18);
            chk({tag, "_busy_cycles"}, 32'(b), 17);
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(done), 0);
        end
    endtask

    initial begin
        int e;
        int b;
        int pulses;
        bit ok;
        logic [19:0] seen;
        int unsigned v;

        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_ovf", 32'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(0, "zero");
        convert(12345, "v12345");
        convert(99999, "v99999");
        convert(9, "v9");
        convert(100000, "v100000");
        convert(131071, "vmax");
        convert(42, "v42");
        for (int i = 0; i < 16; i++) begin
            v = $urandom_range(0, 131071);
            convert(v, "rand");
        end

        // Start pulse during a conversion must be ignored.
        @(negedge clk);
        bin = 17'd54321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin = 17'd11111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        bin = 17'd3;
        pulses = 0;
        seen = '0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                seen = bcd;
            end
        end
        chk("ign_pulses", 32'(pulses), 1);
        chk("ign_bcd", 32'(seen), 32'h54321);

        // Start held high: back-to-back conversions.
        @(negedge clk);
        bin = 17'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        bin = 17'd8;
        wait_done(e, b, ok);
        chk("b2b_done1", 32'(ok), 1);
        chk("b2b_bcd1", 32'(bcd), 32'h7);
        @(posedge clk);
        #1;
        wait_done(e, b, ok);
        start = 1'b0;
        chk("b2b_done2", 32'(ok), 1);
        chk("b2b_gap", 32'(e), 18);
        chk("b2b_bcd2", 32'(bcd), 32'h8);
        @(negedge clk);
        chk("b2b_idle_done", 32'(done), 0);
        chk("b2b_idle_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        bin = 17'd77777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_bcd", 32'(bcd), 0);
        chk("arst_ovf", 32'(ovf), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("arst_no_done", 32'(pulses), 0);
        convert(250, "v250");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
